// File: rtl/rr_multi_grant_scheduler_pkg.sv
// Shared types and helpers for the round-robin multi-grant scheduler.
package rr_multi_grant_scheduler_pkg;

    localparam int RR_REQ_NUM   = 8;
    localparam int RR_GRANT_NUM = 4;

    typedef logic [$clog2(RR_REQ_NUM)-1:0] rr_sched_id_t;

    // Number of set bits; callers zero-extend narrower vectors to 64 bits.
    function automatic int popcount(input logic [63:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            c = c + (v[i] ? 1 : 0);
        end
        return c;
    endfunction

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_multi_grant_scheduler_list.sv
// Ordering datapath: lists the ids of enabled items, scanning circularly
// from start_pos. Entries past the number of enabled items are zero.
module list_enabled_item_id #(
    parameter  int ITEM_NUM = 8,
    localparam int ID_W     = $clog2(ITEM_NUM)
) (
    input  logic [ITEM_NUM-1:0]           seq,
    input  logic [ID_W-1:0]               start_pos,
    output logic [ITEM_NUM-1:0][ID_W-1:0] list
);

    localparam logic [ID_W:0] ITEM_NUM_W = (ID_W+1)'(ITEM_NUM);

    logic [ID_W:0]   pos;
    logic [ID_W-1:0] k;

    // Rotated scan; the wrap is an explicit subtract so non-power-of-two counts work.
    always_comb begin
        list = '0;
        k    = '0;
        pos  = '0;
        for (int i = 0; i < ITEM_NUM; i++) begin
            pos = {1'b0, start_pos} + (ID_W+1)'(i);
            if (pos >= ITEM_NUM_W) begin
                pos = pos - ITEM_NUM_W;
            end
            if (seq[pos[ID_W-1:0]]) begin
                list[k] = pos[ID_W-1:0];
                k       = k + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_multi_grant_scheduler.sv
// Round-robin scheduler granting up to GRANT_NUM of REQ_NUM requesters per
// cycle into a registered output stage with valid/ready toward the consumer.
module rr_multi_grant_scheduler
    import rr_multi_grant_scheduler_pkg::*;
#(
    parameter  int REQ_NUM   = 8,
    parameter  int GRANT_NUM = 4,
    localparam int ID_W      = $clog2(REQ_NUM)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [REQ_NUM-1:0]             req_valid,
    output logic [REQ_NUM-1:0]             req_ready,
    input  logic                           out_ready,
    input  logic                           flush,
    output logic [GRANT_NUM-1:0]           grant_valid,
    output logic [GRANT_NUM-1:0][ID_W-1:0] grant_id,
    output logic [ID_W-1:0]                ptr_o
);

    localparam logic [ID_W-1:0] LAST_POS = ID_W'(REQ_NUM - 1);

    logic [ID_W-1:0]                ptr;
    logic [REQ_NUM-1:0][ID_W-1:0]   list;
    logic [63:0]                    req_ext;
    int                             cnt;
    int                             n;
    logic                           stage_valid;
    logic                           load;
    logic [GRANT_NUM-1:0]           gv_next;
    logic [GRANT_NUM-1:0][ID_W-1:0] gid_next;
    logic [ID_W-1:0]                last_id;
    logic [ID_W-1:0]                ptr_next;

    list_enabled_item_id #(
        .ITEM_NUM (REQ_NUM)
    ) u_list (
        .seq       (req_valid),
        .start_pos (ptr),
        .list      (list)
    );

    assign stage_valid = |grant_valid;
    assign load        = !flush && (!stage_valid || out_ready);
    assign ptr_o       = ptr;

    // Number of grants this cycle: active requesters capped at the slot count.
    always_comb begin
        req_ext                = '0;
        req_ext[REQ_NUM-1:0]   = req_valid;
        cnt                    = popcount(req_ext);
        n                      = min_int(cnt, GRANT_NUM);
    end

    // Candidate stage contents and the pointer just past the last granted id.
    always_comb begin
        gv_next  = '0;
        gid_next = '0;
        last_id  = '0;
        for (int k = 0; k < GRANT_NUM; k++) begin
            if (k < n) begin
                gv_next[k]  = 1'b1;
                gid_next[k] = list[k];
                last_id     = list[k];
            end
        end
        ptr_next = (last_id == LAST_POS) ? '0 : last_id + 1'b1;
    end

    // Acknowledge selected requesters only when the stage actually takes them.
    always_comb begin
        req_ready = '0;
        if (rst && load) begin
            for (int k = 0; k < GRANT_NUM; k++) begin
                if (gv_next[k]) begin
                    req_ready[gid_next[k]] = 1'b1;
                end
            end
        end
    end

    // Stage and fairness pointer: reset, then flush, then load; otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr         <= '0;
            grant_valid <= '0;
            grant_id    <= '0;
        end else if (flush) begin
            grant_valid <= '0;
            grant_id    <= '0;
        end else if (load) begin
            grant_valid <= gv_next;
            grant_id    <= gid_next;
            if (n > 0) begin
                ptr <= ptr_next;
            end
        end
    end

endmodule
